// File: rtl/riscv_biu_sram_resp_pkg.sv
// Shared BIU encodings and the beat helper functions for the SRAM responder.
package riscv_biu_sram_resp_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HWORD = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } biu_size_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } biu_type_t;

  typedef logic [2:0] biu_prot_t;

  // Address arithmetic is done at the widest supported physical width and
  // truncated by the caller.
  localparam int unsigned ADR_W = 64;
  typedef logic [ADR_W-1:0] biu_adr_t;

  // Number of beats in a burst; undefined-length INCR is served as one beat.
  function automatic logic [4:0] biu_burst_len(biu_type_t t);
    case (t)
      WRAP4,  INCR4:  return 5'd4;
      WRAP8,  INCR8:  return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd1;
    endcase
  endfunction

  // Byte enables for an 8-byte lane group; off is the byte offset in the bus word.
  function automatic logic [7:0] biu_be(biu_size_t size, logic [2:0] off);
    logic [7:0] m;
    case (size)
      BYTE:    m = 8'h01;
      HWORD:   m = 8'h03;
      WORD:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m << off;
  endfunction

  // Next beat address; wrapping bursts keep the bits above the wrap span.
  function automatic biu_adr_t biu_nxt_adr(biu_adr_t adr, biu_size_t size, biu_type_t t);
    biu_adr_t step, span, inc;
    step = biu_adr_t'(1) << size;
    inc  = adr + step;
    if (t inside {WRAP4, WRAP8, WRAP16}) begin
      span = step * biu_adr_t'(biu_burst_len(t));
      return (adr & ~(span - 1'b1)) | (inc & (span - 1'b1));
    end
    return inc;
  endfunction

endpackage

// File: rtl/riscv_biu_sram_resp_if.sv
// BIU bus bundle between an initiator (master) and the SRAM responder (slave).
interface riscv_biu_sram_resp_if
  import riscv_biu_sram_resp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PLEN        = 34,
  parameter int BIUTAG_SIZE = 1
);
  logic                   biu_stb_i;
  logic                   biu_stb_ack_o;
  logic                   biu_d_ack_o;
  logic [PLEN-1:0]        biu_adri_i;
  logic [PLEN-1:0]        biu_adro_o;
  biu_size_t              biu_size_i;
  biu_type_t              biu_type_i;
  logic                   biu_we_i;
  logic                   biu_lock_i;
  biu_prot_t              biu_prot_i;
  logic [XLEN-1:0]        biu_d_i;
  logic [XLEN-1:0]        biu_q_o;
  logic                   biu_ack_o;
  logic                   biu_err_o;
  logic [BIUTAG_SIZE-1:0] biu_tagi_i;
  logic [BIUTAG_SIZE-1:0] biu_tago_o;

  modport master (
    output biu_stb_i, biu_adri_i, biu_size_i, biu_type_i, biu_we_i, biu_lock_i,
           biu_prot_i, biu_d_i, biu_tagi_i,
    input  biu_stb_ack_o, biu_d_ack_o, biu_adro_o, biu_q_o, biu_ack_o, biu_err_o,
           biu_tago_o
  );

  modport slave (
    input  biu_stb_i, biu_adri_i, biu_size_i, biu_type_i, biu_we_i, biu_lock_i,
           biu_prot_i, biu_d_i, biu_tagi_i,
    output biu_stb_ack_o, biu_d_ack_o, biu_adro_o, biu_q_o, biu_ack_o, biu_err_o,
           biu_tago_o
  );
endinterface

// File: rtl/riscv_biu_sram_resp_ram.sv
// Generic single-port, byte-enable, write-first SRAM with a one-cycle read.
module riscv_biu_sram_resp_ram #(
  parameter int          XLEN      = 32,
  parameter int          MEM_BYTES = 4096,
  parameter int unsigned AW        = $clog2(MEM_BYTES / (XLEN / 8))
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [XLEN-1:0]   d_i,
  output logic [XLEN-1:0]   q_o
);
  localparam int unsigned DEPTH = MEM_BYTES / (XLEN / 8);

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] wr_word;
  logic [XLEN-1:0] q_d, q_q;

  // Merge enabled write lanes into the stored word; a write returns the merged word.
  always_comb begin
    wr_word = mem[addr_i];
    for (int unsigned i = 0; i < XLEN / 8; i++) begin
      if (be_i[i]) wr_word[i*8 +: 8] = d_i[i*8 +: 8];
    end
    q_d = we_i ? wr_word : mem[addr_i];
  end

  // Array update and registered read port.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem[addr_i] <= wr_word;
      q_q <= q_d;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/riscv_biu_sram_resp.sv
// BIU target serving single and burst requests from an internal SRAM window.
module riscv_biu_sram_resp
  import riscv_biu_sram_resp_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              PLEN        = 34,
  parameter int              MEM_BYTES   = 4096,
  parameter logic [PLEN-1:0] BASE_ADR    = '0,
  parameter int              BIUTAG_SIZE = 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  riscv_biu_sram_resp_if.slave biu
);
  localparam int unsigned BB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BB);
  localparam int unsigned AW    = $clog2(MEM_BYTES / BB);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state_d, state_q;
  logic [PLEN-1:0]        adr_d, adr_q;
  biu_size_t              size_d, size_q;
  biu_type_t              type_d, type_q;
  logic                   we_d, we_q;
  logic [BIUTAG_SIZE-1:0] tag_d, tag_q;
  logic [4:0]             cnt_d, cnt_q;
  logic                   ack_d, ack_q, err_d, err_q, rd_ok_d, rd_ok_q;
  logic [PLEN-1:0]        adro_d, adro_q;
  logic [BIUTAG_SIZE-1:0] tago_d, tago_q;

  logic                   idle, issue, b_we, b_err, mis, in_rng;
  logic [PLEN-1:0]        b_adr, off, nxt_adr;
  biu_size_t              b_size;
  biu_type_t              b_type;
  logic [BIUTAG_SIZE-1:0] b_tag;
  logic [7:0]             be8;
  logic [XLEN-1:0]        ram_q;
  logic                   unused_sig;

  // Current beat comes from the bus in IDLE (accept cycle) and from the latched burst otherwise.
  always_comb begin
    idle    = (state_q == IDLE);
    issue   = idle ? biu.biu_stb_i  : 1'b1;
    b_adr   = idle ? biu.biu_adri_i : adr_q;
    b_size  = idle ? biu.biu_size_i : size_q;
    b_type  = idle ? biu.biu_type_i : type_q;
    b_we    = idle ? biu.biu_we_i   : we_q;
    b_tag   = idle ? biu.biu_tagi_i : tag_q;
    off     = b_adr - BASE_ADR;
    in_rng  = off < PLEN'(MEM_BYTES);
    mis     = (b_adr & ((PLEN'(1) << b_size) - PLEN'(1))) != '0;
    b_err   = ~in_rng | mis | ((b_size == DWORD) && (XLEN < 64)) | (b_type == INCR);
    be8     = biu_be(b_size, 3'(off[OFF_W-1:0]));
    nxt_adr = PLEN'(biu_nxt_adr(biu_adr_t'(b_adr), b_size, b_type));
  end

  // Next-state logic and registered beat response.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    size_d  = size_q;
    type_d  = type_q;
    we_d    = we_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (biu.biu_stb_i) begin
          adr_d  = nxt_adr;
          size_d = biu.biu_size_i;
          type_d = biu.biu_type_i;
          we_d   = biu.biu_we_i;
          tag_d  = biu.biu_tagi_i;
          cnt_d  = biu_burst_len(biu.biu_type_i) - 5'd1;
          if (biu_burst_len(biu.biu_type_i) > 5'd1) state_d = BURST;
        end
      end
      BURST: begin
        adr_d = nxt_adr;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ack_d   = issue & ~b_err;
    err_d   = issue & b_err;
    rd_ok_d = issue & ~b_err & ~b_we;
    adro_d  = issue ? b_adr : '0;
    tago_d  = issue ? b_tag : '0;
  end

  // State and response registers; reset abandons any burst in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      size_q  <= BYTE;
      type_q  <= SINGLE;
      we_q    <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
      adro_q  <= '0;
      tago_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      size_q  <= size_d;
      type_q  <= type_d;
      we_q    <= we_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
      adro_q  <= adro_d;
      tago_q  <= tago_d;
    end
  end

  riscv_biu_sram_resp_ram #(
    .XLEN      (XLEN),
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (issue & ~b_err),
    .we_i   (b_we),
    .be_i   (be8[BB-1:0]),
    .addr_i (off[OFF_W +: AW]),
    .d_i    (biu.biu_d_i),
    .q_o    (ram_q)
  );

  assign biu.biu_stb_ack_o = biu.biu_stb_i & idle;
  assign biu.biu_d_ack_o   = issue & b_we;
  assign biu.biu_ack_o     = ack_q;
  assign biu.biu_err_o     = err_q;
  assign biu.biu_adro_o    = adro_q;
  assign biu.biu_tago_o    = tago_q;
  assign biu.biu_q_o       = rd_ok_q ? ram_q : '0;

  assign unused_sig = ^{biu.biu_lock_i, biu.biu_prot_i, be8};
endmodule

// File: tb/tb_riscv_biu_sram_resp.sv
// Directed plus randomized bench for the BIU SRAM responder with a byte-level memory model.
module tb_riscv_biu_sram_resp;
  import riscv_biu_sram_resp_pkg::*;

  localparam int          XLEN      = 32;
  localparam int          PLEN      = 34;
  localparam int          MEM_BYTES = 4096;
  localparam longint      BASE      = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mdl [MEM_BYTES];

  always #5 clk = ~clk;

  riscv_biu_sram_resp_if #(.XLEN(XLEN), .PLEN(PLEN), .BIUTAG_SIZE(1)) bif ();

  riscv_biu_sram_resp #(
    .XLEN        (XLEN),
    .PLEN        (PLEN),
    .MEM_BYTES   (MEM_BYTES),
    .BASE_ADR    (34'(BASE)),
    .BIUTAG_SIZE (1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .biu   (bif)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(biu_type_t t);
    if (t == WRAP4 || t == INCR4) return 4;
    if (t == WRAP8 || t == INCR8) return 8;
    if (t == WRAP16 || t == INCR16) return 16;
    return 1;
  endfunction

  function automatic logic [31:0] mdl_word(longint a);
    longint w;
    w = a - BASE - (a % 4);
    return {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]};
  endfunction

  // Called at a falling edge; returns at the falling edge after the trailing idle cycle.
  task automatic do_req(input biu_type_t typ, input biu_size_t sz, input longint adr,
                        input bit we, input bit tag, input bit fixed, input logic [31:0] d0);
    int n;
    longint a [16];
    bit e [16];
    logic [31:0] dat [16];
    logic [31:0] q [16];
    longint step, span;
    n    = beats_of(typ);
    step = longint'(1) << int'(sz);
    span = step * n;
    for (int i = 0; i < n; i++) begin
      if (typ == WRAP4 || typ == WRAP8 || typ == WRAP16)
        a[i] = adr - (adr % span) + ((adr % span) + i * step) % span;
      else
        a[i] = adr + i * step;
      e[i] = (a[i] < BASE) || (a[i] >= BASE + MEM_BYTES) || ((a[i] % step) != 0) ||
             (sz == DWORD) || (typ == INCR);
      dat[i] = fixed ? d0 + 32'(i) : $urandom;
      q[i]   = '0;
      if (!e[i]) begin
        if (we) begin
          for (longint j = 0; j < step; j++)
            mdl[a[i] - BASE + j] = dat[i][8*((a[i] % 4) + j) +: 8];
        end else begin
          q[i] = mdl_word(a[i]);
        end
      end
    end
    for (int k = 0; k <= n; k++) begin
      bif.biu_stb_i  = (k < n);
      bif.biu_adri_i = 34'(adr);
      bif.biu_size_i = sz;
      bif.biu_type_i = typ;
      bif.biu_we_i   = we;
      bif.biu_tagi_i = tag;
      bif.biu_d_i    = (k < n) ? dat[k] : '0;
      #1;
      chk("stb_ack", 64'(bif.biu_stb_ack_o), 64'(k == 0));
      chk("d_ack", 64'(bif.biu_d_ack_o), 64'((k < n) && we));
      if (k == 0) begin
        chk("idle_ack", 64'(bif.biu_ack_o), 64'(0));
        chk("idle_err", 64'(bif.biu_err_o), 64'(0));
      end else begin
        chk("ack", 64'(bif.biu_ack_o), 64'(!e[k-1]));
        chk("err", 64'(bif.biu_err_o), 64'(e[k-1]));
        chk("q", 64'(bif.biu_q_o), 64'(q[k-1]));
        chk("adro", 64'(bif.biu_adro_o), 64'(a[k-1]));
        chk("tago", 64'(bif.biu_tago_o), 64'(tag));
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 64'(bif.biu_ack_o), 64'(0));
    chk({tag, "_err"}, 64'(bif.biu_err_o), 64'(0));
    chk({tag, "_q"}, 64'(bif.biu_q_o), 64'(0));
    chk({tag, "_adro"}, 64'(bif.biu_adro_o), 64'(0));
    chk({tag, "_tago"}, 64'(bif.biu_tago_o), 64'(0));
    chk({tag, "_stb_ack"}, 64'(bif.biu_stb_ack_o), 64'(0));
    chk({tag, "_d_ack"}, 64'(bif.biu_d_ack_o), 64'(0));
  endtask

  initial begin
    logic [31:0] rdat [2];
    bif.biu_stb_i  = 1'b0;
    bif.biu_adri_i = '0;
    bif.biu_size_i = WORD;
    bif.biu_type_i = SINGLE;
    bif.biu_we_i   = 1'b0;
    bif.biu_lock_i = 1'b0;
    bif.biu_prot_i = '0;
    bif.biu_d_i    = '0;
    bif.biu_tagi_i = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // preload 0x000..0x1FF
    for (int p = 0; p < 8; p++) do_req(INCR16, WORD, p * 64, 1'b1, 1'b0, 1'b0, '0);

    // single write then read
    do_req(SINGLE, WORD, 'h10, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF);
    do_req(SINGLE, WORD, 'h10, 1'b0, 1'b1, 1'b0, '0);
    chk("model_deadbeef", 64'(mdl_word('h10)), 64'h0000_0000_DEAD_BEEF);

    // wrapping read
    do_req(WRAP4, WORD, 'h18, 1'b0, 1'b1, 1'b0, '0);

    // incrementing write of 1..8 and readback
    do_req(INCR8, WORD, 'h40, 1'b1, 1'b0, 1'b1, 32'd1);
    do_req(INCR8, WORD, 'h40, 1'b0, 1'b0, 1'b0, '0);

    // byte lane merge
    do_req(SINGLE, WORD, 'h20, 1'b1, 1'b0, 1'b1, 32'h11223344);
    do_req(SINGLE, BYTE, 'h21, 1'b1, 1'b1, 1'b1, 32'h0000AA00);
    do_req(SINGLE, WORD, 'h20, 1'b0, 1'b0, 1'b0, '0);
    chk("model_byte_merge", 64'(mdl_word('h20)), 64'h0000_0000_1122_AA44);

    // error cases
    do_req(SINGLE, HWORD, 'h23, 1'b0, 1'b0, 1'b0, '0);
    do_req(SINGLE, WORD, BASE + MEM_BYTES, 1'b0, 1'b1, 1'b0, '0);
    do_req(SINGLE, DWORD, 'h28, 1'b0, 1'b0, 1'b0, '0);
    do_req(INCR, WORD, 'h30, 1'b1, 1'b0, 1'b0, '0);
    do_req(WRAP4, WORD, 'h42, 1'b1, 1'b1, 1'b0, '0);
    do_req(INCR4, WORD, 'h40, 1'b0, 1'b0, 1'b0, '0);

    // top-of-window boundary: two good beats then two out of range
    do_req(INCR4, WORD, 'hFF8, 1'b1, 1'b0, 1'b0, '0);
    do_req(INCR4, WORD, 'hFF8, 1'b0, 1'b1, 1'b0, '0);

    // reset during beat 2 of an INCR8 write
    bif.biu_stb_i  = 1'b1;
    bif.biu_adri_i = 34'h80;
    bif.biu_size_i = WORD;
    bif.biu_type_i = INCR8;
    bif.biu_we_i   = 1'b1;
    bif.biu_tagi_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rdat[k]     = $urandom;
      bif.biu_d_i = rdat[k];
      #1 chk("rst_burst_d_ack", 64'(bif.biu_d_ack_o), 64'(1));
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 4; j++) mdl['h80 + 4*k + j] = rdat[k][8*j +: 8];
    rst = 1'b1;
    bif.biu_stb_i = 1'b0;
    bif.biu_we_i  = 1'b0;
    bif.biu_d_i   = '0;
    #1 chk_all_zero("mid_rst");
    @(negedge clk);
    #1 chk_all_zero("mid_rst_hold");
    @(negedge clk);
    rst = 1'b0;
    do_req(INCR8, WORD, 'h80, 1'b0, 1'b0, 1'b0, '0);

    // randomized traffic in the preloaded region, with some misaligned or out-of-window starts
    for (int r = 0; r < 40; r++) begin
      biu_type_t t;
      biu_size_t s;
      longint    a;
      int        sel;
      t   = biu_type_t'($urandom_range(0, 7));
      s   = biu_size_t'($urandom_range(0, 3));
      a   = longint'($urandom_range(0, 255));
      a   = a - (a % (longint'(1) << int'(s)));
      sel = int'($urandom_range(0, 7));
      if (sel == 0) a = a + 1;
      if (sel == 1) a = a + BASE + MEM_BYTES;
      do_req(t, s, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
